multi_decade_counter: RTL and testbench
=======================================

Name: multi_decade_counter

Overview:
Three-digit BCD up-counter (000 to 999) built from three cascaded decade stages: ones, tens and hundreds. It advances by one on each enabled clock edge. It raises done while the count sits at 999, then wraps to 000. It is a standalone event/cycle counter whose digits feed display or compare logic elsewhere.

Parameters:
none. Digit count fixed at 3, radix fixed at 10.

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high; clears all digits
en  input  1  count enable; count advances on a rising edge when high
ones  output  4  BCD units digit, 0..9
tens  output  4  BCD tens digit, 0..9
hundreds  output  4  BCD hundreds digit, 0..9
done  output  1  high while the count equals 999

Behaviour:
- All digits are registers clocked on rising clk. There is no asynchronous path.
- Reset has priority over en. On a rising edge with reset=1: ones=tens=hundreds=0, so done=0 on the following cycle.
- Reset asserted mid-count clears to 000 on that edge, regardless of en.
- en=0 (reset=0): all digits hold.
- en treated as X/unknown before reset deasserts: the reset edge still forces 000.
- en=1 (reset=0), ones stage:
  - ones<9: ones increments.
  - ones==9: ones goes to 0 and generates carry c1.
- Tens stage:
  - Advances only when c1 is set; otherwise holds.
  - If tens<9: tens increments.
  - If tens==9: tens goes to 0 and generates carry c2.
- Hundreds stage:
  - Advances only when c2 is set; otherwise holds.
  - If hundreds<9: hundreds increments.
  - If hundreds==9: hundreds goes to 0, which is the wrap 999 -> 000.
- Carries are combinational, from the current register values gated by en:
  - c1 = en & (ones==9)
  - c2 = c1 & (tens==9)
- Every digit changes in the same clock edge. There is no ripple latency between stages.
- Digits never hold codes 10..15. If a stage is somehow at a value >9, its next enabled increment forces it to 0 and treats that as a carry.
- done:
  - Combinational: done = (hundreds==9)&(tens==9)&(ones==9).
  - Independent of en, so it stays high indefinitely while en=0 at 999.
  - With en=1, done is high for exactly one cycle per 1000 enabled cycles.
- Wrap: the enabled edge at 999 produces 000 and done drops. Counting continues with no stall.
- Latency:
  - Outputs reflect the new count immediately after the clocking edge.
  - From reset release with en held high, 999 is reached after 999 enabled edges.

Test Plan:
- Reset: reset=1 for 1 edge, en=0 -> ones/tens/hundreds=0, done=0; holds at 000 for 5 idle cycles.
- Basic count: en=1 for 9 edges -> ones=9, tens=0. 10th edge -> ones=0, tens=1. At 99 plus one edge -> 100.
- Full run: en=1 continuously from 000 -> done rises after exactly 999 edges with digits 9/9/9. The next edge gives 0/0/0 with done=0.
- Hold: at count 457, drop en for 10 cycles -> digits stay 4/5/7. Reassert en -> next edge gives 458. At 999 with en=0 -> done stays 1.
- Mid-count reset: count at 321 with en=1, assert reset for 1 edge -> 000 on that edge (reset wins over en). Release -> next enabled edge gives 001.
- Digit legality: across a full 1000-edge wrap, every digit stays within 0..9, and each carry occurs exactly once per digit rollover.

Source files
------------

// File: rtl/multi_decade_counter.sv
// -----------------------------------------------------------------------------
// multi_decade_counter
//   Three-digit BCD up-counter (000..999) built from three cascaded decade
//   stages. All digits advance on the same rising edge; carries between stages
//   are combinational, so there is no ripple latency. done is high while the
//   count sits at 999 and the next enabled edge wraps to 000.
//
// Ports
//   clk      in   1  system clock, rising-edge active
//   reset    in   1  synchronous active-high clear; has priority over en
//   en       in   1  count enable
//   ones     out  4  BCD units digit
//   tens     out  4  BCD tens digit
//   hundreds out  4  BCD hundreds digit
//   done     out  1  high while the count equals 999
// -----------------------------------------------------------------------------
module multi_decade_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic [3:0] hundreds,
    output logic       done
);

    // A stage carries out when it advances from 9, or from any illegal code
    // above 9 so that a corrupted digit recovers on its next advance.
    function automatic logic digit_carry(input logic [3:0] d, input logic cin);
        logic c;
        if (cin && (d >= 4'd9)) begin
            c = 1'b1;
        end else begin
            c = 1'b0;
        end
        return c;
    endfunction

    // Next value of one decade stage given its carry-in.
    function automatic logic [3:0] digit_next(input logic [3:0] d, input logic cin);
        logic [3:0] n;
        if (!cin) begin
            n = d;
        end else if (d >= 4'd9) begin
            n = 4'd0;
        end else begin
            n = d + 4'd1;
        end
        return n;
    endfunction

    logic [3:0] ones_r;
    logic [3:0] tens_r;
    logic [3:0] hundreds_r;
    logic       done_r;

    logic       c1_s;
    logic       c2_s;
    logic [3:0] ones_nxt_s;
    logic [3:0] tens_nxt_s;
    logic [3:0] hundreds_nxt_s;
    logic       done_nxt_s;

    // Carry chain and next-digit values for the enabled-edge update.
    always_comb begin
        c1_s           = digit_carry(ones_r, en);
        c2_s           = digit_carry(tens_r, c1_s);
        ones_nxt_s     = digit_next(ones_r, en);
        tens_nxt_s     = digit_next(tens_r, c1_s);
        hundreds_nxt_s = digit_next(hundreds_r, c2_s);
        // done is registered from the next count, so it lines up exactly with
        // the digit registers holding 999.
        if ((hundreds_nxt_s == 4'd9) && (tens_nxt_s == 4'd9) && (ones_nxt_s == 4'd9)) begin
            done_nxt_s = 1'b1;
        end else begin
            done_nxt_s = 1'b0;
        end
    end

    // Digit and done registers: reset wins, otherwise advance when enabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            ones_r     <= 4'd0;
            tens_r     <= 4'd0;
            hundreds_r <= 4'd0;
            done_r     <= 1'b0;
        end else if (en) begin
            ones_r     <= ones_nxt_s;
            tens_r     <= tens_nxt_s;
            hundreds_r <= hundreds_nxt_s;
            done_r     <= done_nxt_s;
        end else begin
            ones_r     <= ones_r;
            tens_r     <= tens_r;
            hundreds_r <= hundreds_r;
            done_r     <= done_r;
        end
    end

    assign ones     = ones_r;
    assign tens     = tens_r;
    assign hundreds = hundreds_r;
    assign done     = done_r;

endmodule

// File: tb/tb_multi_decade_counter.sv
// -----------------------------------------------------------------------------
// tb_multi_decade_counter
//   Table-driven directed vectors for reset and early counting, followed by
//   hand-written sequences for the 99->100 step, full 1000-edge wrap, hold with
//   en low, done persistence at 999 and mid-count reset.
// -----------------------------------------------------------------------------
module tb_multi_decade_counter;

    logic       clk;
    logic       reset;
    logic       en;
    logic [3:0] ones;
    logic [3:0] tens;
    logic [3:0] hundreds;
    logic       done;

    int total = 0;
    int bad   = 0;
    int model = 0;

    typedef struct {
        logic       reset;
        logic       en;
        logic [3:0] exp_ones;
        logic [3:0] exp_tens;
        logic [3:0] exp_hundreds;
        logic       exp_done;
    } vec_t;

    vec_t vecs [16];

    multi_decade_counter dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .ones     (ones),
        .tens     (tens),
        .hundreds (hundreds),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply inputs, take one rising edge, then sample 1 time unit later.
    task automatic step(input logic r, input logic e);
        reset = r;
        en    = e;
        @(posedge clk);
        #1;
        if (r === 1'b1) begin
            model = 0;
        end else if (e === 1'b1) begin
            model = (model + 1) % 1000;
        end
    endtask

    task automatic check_raw(input string name, input logic [3:0] eo, input logic [3:0] et,
                             input logic [3:0] eh, input logic ed);
        total++;
        if (ones !== eo || tens !== et || hundreds !== eh || done !== ed) begin
            bad++;
            $display("FAIL %s: got h=%0d t=%0d o=%0d done=%0b, want h=%0d t=%0d o=%0d done=%0b",
                     name, hundreds, tens, ones, done, eh, et, eo, ed);
        end
    endtask

    // Compare against the bench's own integer count.
    task automatic check_model(input string name);
        logic [3:0] eo;
        logic [3:0] et;
        logic [3:0] eh;
        eo = 4'(model % 10);
        et = 4'((model / 10) % 10);
        eh = 4'(model / 100);
        check_raw(name, eo, et, eh, (model == 999) ? 1'b1 : 1'b0);
    endtask

    initial begin
        int tens_changes;
        int hund_changes;
        int first_done;
        logic [3:0] prev_t;
        logic [3:0] prev_h;

        reset = 1'b1;
        en    = 1'bx;

        // reset with en unknown, five idle cycles, then ten enabled edges
        vecs[0]  = '{1'b1, 1'bx, 4'd0, 4'd0, 4'd0, 1'b0};
        for (int i = 1; i <= 5; i++) begin
            vecs[i] = '{1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0};
        end
        vecs[6]  = '{1'b0, 1'b1, 4'd1, 4'd0, 4'd0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 4'd2, 4'd0, 4'd0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 4'd3, 4'd0, 4'd0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 4'd4, 4'd0, 4'd0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 4'd5, 4'd0, 4'd0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 4'd6, 4'd0, 4'd0, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 4'd7, 4'd0, 4'd0, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 4'd8, 4'd0, 4'd0, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 4'd9, 4'd0, 4'd0, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 4'd0, 4'd1, 4'd0, 1'b0};

        for (int i = 0; i < 16; i++) begin
            step(vecs[i].reset, vecs[i].en);
            check_raw($sformatf("vec%0d", i), vecs[i].exp_ones, vecs[i].exp_tens,
                      vecs[i].exp_hundreds, vecs[i].exp_done);
        end

        // 10 -> 99, then 99 -> 100
        for (int i = 0; i < 89; i++) step(1'b0, 1'b1);
        check_raw("at_99", 4'd9, 4'd9, 4'd0, 1'b0);
        step(1'b0, 1'b1);
        check_raw("at_100", 4'd0, 4'd0, 4'd1, 1'b0);

        // full run from 000: done first rises after exactly 999 edges
        step(1'b1, 1'b0);
        check_raw("full_reset", 4'd0, 4'd0, 4'd0, 1'b0);
        tens_changes = 0;
        hund_changes = 0;
        first_done   = -1;
        prev_t       = tens;
        prev_h       = hundreds;
        for (int i = 1; i <= 1000; i++) begin
            step(1'b0, 1'b1);
            check_model($sformatf("full_edge%0d", i));
            if (ones > 4'd9 || tens > 4'd9 || hundreds > 4'd9) begin
                total++;
                bad++;
                $display("FAIL legal_edge%0d: got h=%0d t=%0d o=%0d, want all digits 0..9",
                         i, hundreds, tens, ones);
            end
            if (done === 1'b1 && first_done < 0) first_done = i;
            if (tens !== prev_t) tens_changes++;
            if (hundreds !== prev_h) hund_changes++;
            prev_t = tens;
            prev_h = hundreds;
        end
        total++;
        if (first_done != 999) begin
            bad++;
            $display("FAIL done_first_edge: got %0d, want 999", first_done);
        end
        total++;
        if (tens_changes != 100) begin
            bad++;
            $display("FAIL tens_carries: got %0d, want 100", tens_changes);
        end
        total++;
        if (hund_changes != 10) begin
            bad++;
            $display("FAIL hundreds_carries: got %0d, want 10", hund_changes);
        end
        check_raw("after_wrap", 4'd0, 4'd0, 4'd0, 1'b0);

        // hold at 457 for 10 cycles, then 458
        step(1'b1, 1'b0);
        for (int i = 0; i < 457; i++) step(1'b0, 1'b1);
        check_raw("at_457", 4'd7, 4'd5, 4'd4, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0);
            check_raw($sformatf("hold457_%0d", i), 4'd7, 4'd5, 4'd4, 1'b0);
        end
        step(1'b0, 1'b1);
        check_raw("at_458", 4'd8, 4'd5, 4'd4, 1'b0);

        // reach 999 and hold there: done stays high
        for (int i = 0; i < 541; i++) step(1'b0, 1'b1);
        check_raw("at_999", 4'd9, 4'd9, 4'd9, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0);
            check_raw($sformatf("hold999_%0d", i), 4'd9, 4'd9, 4'd9, 1'b1);
        end
        step(1'b0, 1'b1);
        check_raw("wrap_after_hold", 4'd0, 4'd0, 4'd0, 1'b0);

        // mid-count reset at 321 with en high
        for (int i = 0; i < 321; i++) step(1'b0, 1'b1);
        check_raw("at_321", 4'd1, 4'd2, 4'd3, 1'b0);
        step(1'b1, 1'b1);
        check_raw("reset_wins", 4'd0, 4'd0, 4'd0, 1'b0);
        step(1'b0, 1'b1);
        check_raw("after_reset_001", 4'd1, 4'd0, 4'd0, 1'b0);
        check_model("model_001");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
